// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage of the 16-bit SIMPLE core.
// Owns the program counter and issues one word fetch at a time over a
// req/ack handshake. Fetched words go to decode through a one-entry
// valid/ready output register. A taken branch (pcsrc) redirects fetch and
// squashes wrong-path data. A halt from decode parks the unit until reset.
//
// Optional build macro: PC_FETCH_PERF_EN adds the saturating counters
// perf_fetches (buffer loads) and perf_flushes (pcsrc cycles outside HALTED).
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus_1,
    input  logic        pcsrc,
    input  logic [15:0] branch_addr,
    input  logic        halt,
    output logic        halted
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetches,
    output logic [15:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_DROP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;          // address of the outstanding request
    logic        req_q, req_d;            // a request is held waiting for ack
    logic        halt_pend_q, halt_pend_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc_plus_1_q, if_pc_plus_1_d;

    logic        can_take_s;
    logic        launch_s;
    logic        imem_req_s;
    logic [15:0] imem_addr_s;
    logic        ack_s;
    logic        load_s;

    // A new request starts only when the buffer will have room at the edge,
    // and not in a cycle that is about to redirect or halt.
    assign can_take_s  = ~if_valid_q | if_ready;
    assign launch_s    = (state_q == ST_REQ) & ~req_q & can_take_s & ~pcsrc & ~halt;
    assign imem_req_s  = req_q | launch_s;
    assign imem_addr_s = req_q ? addr_q : pc_q;
    assign ack_s       = imem_req_s & imem_ack;

    // Next-state, program counter and output-register update.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        addr_d         = addr_q;
        req_d          = req_q;
        halt_pend_d    = halt_pend_q;
        if_valid_d     = if_valid_q & ~if_ready;
        if_instr_d     = if_instr_q;
        if_pc_plus_1_d = if_pc_plus_1_q;
        load_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pcsrc) begin
                    pc_d = branch_addr;
                end else begin
                    pc_d = pc_q;
                end
                if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ, ST_DROP: begin
                if (pcsrc) begin
                    // Redirect wins: new pc, squash the buffer and any ack data.
                    pc_d       = branch_addr;
                    if_valid_d = 1'b0;
                    if (req_q && !imem_ack) begin
                        // The old request must still complete; its data is junk.
                        state_d     = ST_DROP;
                        req_d       = 1'b1;
                        halt_pend_d = halt_pend_q | halt;
                    end else begin
                        req_d       = 1'b0;
                        halt_pend_d = 1'b0;
                        if (halt || halt_pend_q) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end else if (ack_s) begin
                    req_d       = 1'b0;
                    halt_pend_d = 1'b0;
                    if (state_q == ST_REQ) begin
                        load_s = 1'b1;
                        pc_d   = pc_q + 16'd1;
                    end else begin
                        // Wrong-path data from DROP: pc already holds the target.
                        load_s = 1'b0;
                        pc_d   = pc_q;
                    end
                    if (halt || halt_pend_q) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    if (launch_s) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end else begin
                        req_d  = req_q;
                        addr_d = addr_q;
                    end
                    if (halt) begin
                        if (req_q) begin
                            halt_pend_d = 1'b1;
                        end else begin
                            state_d = ST_HALTED;
                        end
                    end else begin
                        halt_pend_d = halt_pend_q;
                    end
                end
            end

            ST_HALTED: begin
                state_d     = ST_HALTED;
                req_d       = 1'b0;
                halt_pend_d = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                req_d       = 1'b0;
                halt_pend_d = 1'b0;
                if_valid_d  = 1'b0;
            end
        endcase

        if (load_s) begin
            if_valid_d     = 1'b1;
            if_instr_d     = imem_rdata;
            if_pc_plus_1_d = imem_addr_s + 16'd1;
        end else begin
            if_instr_d     = if_instr_q;
            if_pc_plus_1_d = if_pc_plus_1_q;
        end
    end

    // State, program counter and output register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            addr_q         <= RESET_PC;
            req_q          <= 1'b0;
            halt_pend_q    <= 1'b0;
            if_valid_q     <= 1'b0;
            if_instr_q     <= 16'h0000;
            if_pc_plus_1_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            addr_q         <= addr_d;
            req_q          <= req_d;
            halt_pend_q    <= halt_pend_d;
            if_valid_q     <= if_valid_d;
            if_instr_q     <= if_instr_d;
            if_pc_plus_1_q <= if_pc_plus_1_d;
        end
    end

    assign imem_req     = imem_req_s;
    assign imem_addr    = imem_addr_s;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc_plus_1 = if_pc_plus_1_q;
    assign halted       = (state_q == ST_HALTED);

`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetches_q, perf_fetches_d;
    logic [15:0] perf_flushes_q, perf_flushes_d;
    logic        flush_s;

    assign flush_s = pcsrc & (state_q != ST_HALTED);

    // Saturating event counters for loads and redirects.
    always_comb begin
        perf_fetches_d = perf_fetches_q;
        perf_flushes_d = perf_flushes_q;
        if (load_s && (perf_fetches_q != 32'hFFFF_FFFF)) begin
            perf_fetches_d = perf_fetches_q + 32'd1;
        end else begin
            perf_fetches_d = perf_fetches_q;
        end
        if (flush_s && (perf_flushes_q != 16'hFFFF)) begin
            perf_flushes_d = perf_flushes_q + 16'd1;
        end else begin
            perf_flushes_d = perf_flushes_q;
        end
    end

    // Counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches_q <= 32'd0;
            perf_flushes_q <= 16'd0;
        end else begin
            perf_fetches_q <= perf_fetches_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit SIMPLE core.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Presents fetched instructions to decode through a one-entry output register with valid/ready.
- Consumes the taken-branch redirect (pcsrc, branch_addr) produced by the branch calculator in the execute stage, and flushes wrong-path fetches.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; first fetch address.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  16  word address of the fetch; stable while imem_req=1
imem_ack  in  1  request accepted and imem_rdata valid in this cycle
imem_rdata  in  16  instruction word
if_valid  out  1  if_instr/if_pc_plus_1 hold a valid instruction
if_ready  in  1  decode accepts the instruction this cycle
if_instr  out  16  fetched instruction
if_pc_plus_1  out  16  fetch address + 1, mod 2^16
pcsrc  in  1  taken branch; redirect fetch this cycle
branch_addr  in  16  redirect target
halt  in  1  decode has seen HLT; stop fetching
halted  out  1  fetch unit is in HALTED

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, if_valid=0, if_instr=0, if_pc_plus_1=0, halted=0.
- States: IDLE, REQ, DROP, HALTED.
- IDLE: one cycle after reset release, then REQ. No request is issued.
- REQ:
  - imem_req=1 and imem_addr=pc only when the buffer can take data: if_valid=0, or if_valid&if_ready in the same cycle. Otherwise imem_req=0 and stay in REQ.
  - A request, once raised, stays high with a constant address until ack, regardless of if_ready.
  - On imem_ack: if_instr<=imem_rdata, if_pc_plus_1<=pc+1, if_valid<=1, pc<=pc+1.
  - Minimum fetch latency is 1 cycle (ack in the same cycle as req). Sustained throughput is one instruction per cycle when ack is immediate and if_ready=1.
- Output register: if_valid&if_ready with no new ack clears if_valid. if_instr and if_pc_plus_1 only change on load.
- Redirect (pcsrc=1) has highest priority over everything except reset:
  - pc<=branch_addr and if_valid<=0 on the same edge. Any ack data in that cycle is discarded.
  - If a request is outstanding and imem_ack=0 in that cycle, go to DROP. Otherwise go to REQ.
- DROP:
  - Keep imem_req=1 and the old imem_addr until imem_ack, then discard the data and go to REQ (fetch at the redirected pc).
  - A second pcsrc while in DROP updates pc only.
- Halt:
  - On halt=1 with no outstanding request, go to HALTED.
  - With a request outstanding, complete it (load the buffer normally), then go to HALTED.
  - HALTED: imem_req=0, halted=1. pcsrc and halt are ignored. if_valid still drains via if_ready. Exit only by reset.
  - pcsrc and halt in the same cycle: redirect is applied, then HALTED.
- Arithmetic: pc+1 wraps 16'hFFFF to 16'h0000. No other width extension.
- Reset mid-request: the request is dropped immediately. The memory side must tolerate req falling without ack on reset.
- Invariant: at most one outstanding request. imem_addr must not change while imem_req=1.

Optional Feature:
PC_FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetches (32-bit), perf_flushes (16-bit), both reset to 0.
  - perf_fetches increments on each ack loaded into the buffer.
  - perf_flushes increments on each pcsrc=1 cycle outside HALTED.
  - Both saturate at all-ones.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=16'h0010, imem_ack tied 1, if_ready=1 -> imem_addr 0010, 0011, 0012 on consecutive cycles; if_pc_plus_1 0011, 0012, 0013; one instruction per cycle.
- if_ready=0 for 3 cycles with a full buffer -> imem_req=0; if_instr and if_valid stable; fetch resumes the cycle if_ready returns to 1.
- Request at 0020 with ack delayed 2 cycles, pcsrc=1 and branch_addr=0100 on the first wait cycle -> enter DROP; addr stays 0020 until ack; data discarded; next request at 0100; if_valid=0 throughout.
- pc=FFFF, ack immediate -> if_pc_plus_1=0000; next imem_addr=0000.
- halt=1 while a request at 0030 is pending -> ack loads the buffer; halted=1 next cycle; imem_req=0 forever; a later pcsrc has no effect until rst_n pulse.
- rst_n=0 mid-request -> imem_req=0, if_valid=0, pc=RESET_PC asynchronously, without waiting for a clock edge.
